// File: rtl/ahb2apb_multi16_if.sv
// rtl/ahb2apb_multi16_if.sv - AHB-Lite / APB3 signal bundle for the ahb2apb_multi16 bridge
//
// Purpose: groups the AHB slave-side and APB master-side signals of the bridge.
// Modports:
//   slave  - bridge view: AHB request in, AHB response out, APB request out,
//            APB response in.
//   master - environment view (AHB master plus APB peripherals), the mirror image.
// Signals:
//   hsel16, haddr16[31:0], htrans16[1:0], hwrite16, hwdata16[31:0], hready_in16
//   hrdata16[31:0], hready16, hresp16[1:0]
//   paddr16[31:0], pwrite16, penable16, pwdata16[31:0], psel16[NUM_SLV-1:0]
//   prdata16[32*NUM_SLV-1:0], pready16[NUM_SLV-1:0], pslverr16[NUM_SLV-1:0]
interface ahb2apb_multi16_if #(
  parameter int NUM_SLV = 5
);
  logic                   hsel16;
  logic [31:0]            haddr16;
  logic [1:0]             htrans16;
  logic                   hwrite16;
  logic [31:0]            hwdata16;
  logic                   hready_in16;
  logic [31:0]            hrdata16;
  logic                   hready16;
  logic [1:0]             hresp16;
  logic [31:0]            paddr16;
  logic                   pwrite16;
  logic                   penable16;
  logic [31:0]            pwdata16;
  logic [NUM_SLV-1:0]     psel16;
  logic [32*NUM_SLV-1:0]  prdata16;
  logic [NUM_SLV-1:0]     pready16;
  logic [NUM_SLV-1:0]     pslverr16;

  modport slave (
    input  hsel16, haddr16, htrans16, hwrite16, hwdata16, hready_in16,
    output hrdata16, hready16, hresp16,
    output paddr16, pwrite16, penable16, pwdata16, psel16,
    input  prdata16, pready16, pslverr16
  );

  modport master (
    output hsel16, haddr16, htrans16, hwrite16, hwdata16, hready_in16,
    input  hrdata16, hready16, hresp16,
    input  paddr16, pwrite16, penable16, pwdata16, psel16,
    output prdata16, pready16, pslverr16
  );
endinterface

// File: rtl/ahb2apb_multi16.sv
// rtl/ahb2apb_multi16.sv - single-clock AHB-Lite slave to APB3 master bridge, NUM_SLV regions
//
// Purpose: decodes NUM_SLV contiguous, equal, power-of-two regions starting at
// BASE_ADDR, runs one APB3 SETUP/ACCESS sequence per accepted AHB transfer,
// honours PREADY wait states, maps PSLVERR and unmapped addresses to a
// two-cycle AHB ERROR response. All outputs are registered.
// Ports:
//   hclk16      - clock for both AHB and APB sides
//   n_hreset16  - synchronous active-low reset
//   bus         - ahb2apb_multi16_if.slave (AHB request/response, APB request/response)
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase with an
// ERROR response after TIMEOUT_CYCLES cycles without PREADY.
module ahb2apb_multi16 #(
  parameter int          NUM_SLV        = 5,
  parameter logic [31:0] BASE_ADDR      = 32'h00A00000,
  parameter logic [31:0] REGION_SIZE    = 32'h00010000,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic              hclk16,
  input  logic              n_hreset16,
  ahb2apb_multi16_if.slave  bus
);

  localparam int IDX_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int RS_LOG2 = $clog2(REGION_SIZE);

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic [31:0]        hrdata_q, hrdata_d;
  logic               hready_q, hready_d;
  logic [1:0]         hresp_q, hresp_d;
  logic               penable_q, penable_d;
  logic [NUM_SLV-1:0] psel_q, psel_d;

  logic [31:0]        dec_off;
  logic [31:0]        dec_idx_full;
  logic               dec_hit;
  logic [31:0]        sel_rdata;
  logic               sel_ready;
  logic               sel_err;
  logic               timeout_hit;

  // Only the NONSEQ/SEQ bit of htrans matters; IDLE and BUSY are ignored.
  logic unused_htrans0;
  assign unused_htrans0 = bus.htrans16[0];

  // Region decode; the subtraction wraps for addresses below the base, which
  // the explicit lower-bound test rejects.
  assign dec_off      = bus.haddr16 - BASE_ADDR;
  assign dec_idx_full = dec_off >> RS_LOG2;
  assign dec_hit      = (bus.haddr16 >= BASE_ADDR) && (dec_idx_full < 32'(NUM_SLV));

  // Response of the currently addressed slave.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_rdata = bus.prdata16[i*32 +: 32];
        sel_ready = bus.pready16[i];
        sel_err   = bus.pslverr16[i];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counts ACCESS cycles; value N-1 during the Nth ACCESS cycle.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == S_SETUP) begin
      tmo_cnt_d = '0;
    end else if (state_q == S_ACCESS) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == S_ACCESS) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge hclk16) begin
    if (!n_hreset16) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR2: begin
        state_d = S_IDLE;
        if (bus.hsel16 && bus.htrans16[1] && bus.hready_in16) begin
          if (dec_hit) begin
            idx_d    = dec_idx_full[IDX_W-1:0];
            paddr_d  = bus.haddr16;
            pwrite_d = bus.hwrite16;
            state_d  = bus.hwrite16 ? S_WDATA : S_SETUP;
          end else begin
            state_d = S_ERR1;
          end
        end
      end
      S_WDATA: begin
        // AHB write data is valid in the data phase, one cycle after address.
        pwdata_d = bus.hwdata16;
        state_d  = S_SETUP;
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (sel_ready) begin
          if (sel_err) begin
            state_d = S_ERR1;
          end else begin
            state_d = S_DONE;
            if (!pwrite_q) begin
              hrdata_d = sel_rdata;
            end
          end
        end else if (timeout_hit) begin
          state_d = S_ERR1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    hready_d  = (state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR2);
    hresp_d   = ((state_d == S_ERR1) || (state_d == S_ERR2)) ? 2'b01 : 2'b00;
    penable_d = (state_d == S_ACCESS);
    psel_d    = '0;
    if ((state_d == S_SETUP) || (state_d == S_ACCESS)) begin
      for (int i = 0; i < NUM_SLV; i++) begin
        psel_d[i] = (idx_d == IDX_W'(i));
      end
    end
  end

  always_ff @(posedge hclk16) begin
    if (!n_hreset16) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      hrdata_q  <= '0;
      hready_q  <= 1'b1;
      hresp_q   <= 2'b00;
      penable_q <= 1'b0;
      psel_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      hrdata_q  <= hrdata_d;
      hready_q  <= hready_d;
      hresp_q   <= hresp_d;
      penable_q <= penable_d;
      psel_q    <= psel_d;
    end
  end

  assign bus.hrdata16  = hrdata_q;
  assign bus.hready16  = hready_q;
  assign bus.hresp16   = hresp_q;
  assign bus.paddr16   = paddr_q;
  assign bus.pwrite16  = pwrite_q;
  assign bus.penable16 = penable_q;
  assign bus.pwdata16  = pwdata_q;
  assign bus.psel16    = psel_q;

endmodule

// File: tb/tb_ahb2apb_multi16.sv
// tb/tb_ahb2apb_multi16.sv - directed self-checking bench for ahb2apb_multi16
module tb_ahb2apb_multi16;
  localparam int NS = 5;

  logic clk = 1'b0;
  logic rstn;
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  ahb2apb_multi16_if #(.NUM_SLV(NS)) bus ();

  ahb2apb_multi16 #(
    .NUM_SLV(NS),
    .BASE_ADDR(32'h00A00000),
    .REGION_SIZE(32'h00010000),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .hclk16(clk),
    .n_hreset16(rstn),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w);
    bus.hsel16   = 1'b1;
    bus.haddr16  = a;
    bus.htrans16 = 2'b10;
    bus.hwrite16 = w;
  endtask

  task automatic bus_idle();
    bus.hsel16   = 1'b0;
    bus.htrans16 = 2'b00;
  endtask

  task automatic set_slave(input int i, input logic rdy, input logic err, input logic [31:0] d);
    bus.pready16[i]            = rdy;
    bus.pslverr16[i]           = err;
    bus.prdata16[i*32 +: 32]   = d;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.hsel16 = 1'b0; bus.haddr16 = '0; bus.htrans16 = 2'b00; bus.hwrite16 = 1'b0;
    bus.hwdata16 = '0; bus.hready_in16 = 1'b1;
    bus.prdata16 = '0; bus.pready16 = '0; bus.pslverr16 = '0;
    tick();
    tick();
    tests++; if (bus.hready16 !== 1'b1) begin failed++; $display("FAIL rst_hready got=%b exp=1", bus.hready16); end
    tests++; if (bus.hresp16 !== 2'b00) begin failed++; $display("FAIL rst_hresp got=%b exp=00", bus.hresp16); end
    tests++; if (bus.hrdata16 !== 32'h0) begin failed++; $display("FAIL rst_hrdata got=%h exp=0", bus.hrdata16); end
    tests++; if ({bus.psel16, bus.penable16, bus.pwrite16} !== 7'b0) begin failed++; $display("FAIL rst_apb_ctl got=%b exp=0", {bus.psel16, bus.penable16, bus.pwrite16}); end
    tests++; if ({bus.paddr16, bus.pwdata16} !== 64'h0) begin failed++; $display("FAIL rst_apb_data got=%h exp=0", {bus.paddr16, bus.pwdata16}); end
    rstn = 1'b1;
  endtask

  task automatic test_read();
    set_slave(2, 1'b1, 1'b0, 32'hDEADBEEF);
    addr_phase(32'h00A20004, 1'b0);
    tests++; if (bus.hready16 !== 1'b1) begin failed++; $display("FAIL rd_idle_hready got=%b exp=1", bus.hready16); end
    tick(); bus_idle();
    tests++; if (bus.psel16 !== 5'b00100 || bus.penable16 !== 1'b0) begin failed++; $display("FAIL rd_setup got psel=%b pen=%b exp psel=00100 pen=0", bus.psel16, bus.penable16); end
    tests++; if (bus.paddr16 !== 32'h00A20004 || bus.pwrite16 !== 1'b0 || bus.hready16 !== 1'b0) begin failed++; $display("FAIL rd_setup_addr got paddr=%h pw=%b hrdy=%b exp 00a20004 0 0", bus.paddr16, bus.pwrite16, bus.hready16); end
    tick();
    tests++; if (bus.psel16 !== 5'b00100 || bus.penable16 !== 1'b1 || bus.hready16 !== 1'b0) begin failed++; $display("FAIL rd_access got psel=%b pen=%b hrdy=%b exp 00100 1 0", bus.psel16, bus.penable16, bus.hready16); end
    tick();
    tests++; if (bus.hready16 !== 1'b1 || bus.hresp16 !== 2'b00) begin failed++; $display("FAIL rd_done_resp got hrdy=%b hresp=%b exp 1 00", bus.hready16, bus.hresp16); end
    tests++; if (bus.hrdata16 !== 32'hDEADBEEF) begin failed++; $display("FAIL rd_done_data got=%h exp=deadbeef", bus.hrdata16); end
    tests++; if (bus.psel16 !== 5'b0 || bus.penable16 !== 1'b0) begin failed++; $display("FAIL rd_done_apb got psel=%b pen=%b exp 0 0", bus.psel16, bus.penable16); end
    tick();
  endtask

  task automatic test_write_wait();
    int en_cnt;
    en_cnt = 0;
    set_slave(0, 1'b0, 1'b0, 32'h0);
    addr_phase(32'h00A00010, 1'b1);
    tick(); bus_idle(); bus.hwdata16 = 32'h12345678;
    tests++; if (bus.hready16 !== 1'b0 || bus.psel16 !== 5'b0) begin failed++; $display("FAIL wr_wdata got hrdy=%b psel=%b exp 0 0", bus.hready16, bus.psel16); end
    tick(); bus.hwdata16 = 32'hFFFFFFFF;
    tests++; if (bus.psel16 !== 5'b00001 || bus.penable16 !== 1'b0 || bus.pwrite16 !== 1'b1) begin failed++; $display("FAIL wr_setup got psel=%b pen=%b pw=%b exp 00001 0 1", bus.psel16, bus.penable16, bus.pwrite16); end
    tests++; if (bus.pwdata16 !== 32'h12345678 || bus.paddr16 !== 32'h00A00010) begin failed++; $display("FAIL wr_setup_data got pwdata=%h paddr=%h exp 12345678 00a00010", bus.pwdata16, bus.paddr16); end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) bus.pready16[0] = 1'b1;
      if (bus.penable16 === 1'b1) en_cnt++;
      tests++;
      if ({bus.psel16, bus.pwdata16, bus.paddr16, bus.hready16} !== {5'b00001, 32'h12345678, 32'h00A00010, 1'b0}) begin
        failed++; $display("FAIL wr_access_stable cyc=%0d got psel=%b pwdata=%h paddr=%h hrdy=%b", k, bus.psel16, bus.pwdata16, bus.paddr16, bus.hready16);
      end
    end
    tick();
    tests++; if (en_cnt !== 4) begin failed++; $display("FAIL wr_penable_cycles got=%0d exp=4", en_cnt); end
    tests++; if (bus.hready16 !== 1'b1 || bus.hresp16 !== 2'b00 || bus.penable16 !== 1'b0) begin failed++; $display("FAIL wr_done got hrdy=%b hresp=%b pen=%b exp 1 00 0", bus.hready16, bus.hresp16, bus.penable16); end
    tests++; if (bus.hrdata16 !== 32'hDEADBEEF) begin failed++; $display("FAIL wr_hrdata_hold got=%h exp=deadbeef", bus.hrdata16); end
    bus.pready16[0] = 1'b0;
    tick();
  endtask

  task automatic test_miss();
    addr_phase(32'h00A50000, 1'b0);
    tick(); bus_idle();
    tests++; if (bus.psel16 !== 5'b0 || bus.hready16 !== 1'b0 || bus.hresp16 !== 2'b01) begin failed++; $display("FAIL miss_err1 got psel=%b hrdy=%b hresp=%b exp 0 0 01", bus.psel16, bus.hready16, bus.hresp16); end
    tick();
    tests++; if (bus.psel16 !== 5'b0 || bus.hready16 !== 1'b1 || bus.hresp16 !== 2'b01) begin failed++; $display("FAIL miss_err2 got psel=%b hrdy=%b hresp=%b exp 0 1 01", bus.psel16, bus.hready16, bus.hresp16); end
    tick();
    tests++; if (bus.hready16 !== 1'b1 || bus.hresp16 !== 2'b00) begin failed++; $display("FAIL miss_idle got hrdy=%b hresp=%b exp 1 00", bus.hready16, bus.hresp16); end
    addr_phase(32'h009FFFFC, 1'b1);
    tick(); bus_idle();
    tests++; if (bus.psel16 !== 5'b0 || bus.hready16 !== 1'b0 || bus.hresp16 !== 2'b01) begin failed++; $display("FAIL below_base got psel=%b hrdy=%b hresp=%b exp 0 0 01", bus.psel16, bus.hready16, bus.hresp16); end
    tick(); tick();
    bus.hsel16 = 1'b1; bus.haddr16 = 32'h00A20000; bus.htrans16 = 2'b00; bus.hwrite16 = 1'b0;
    tick(); bus_idle();
    tests++; if (bus.psel16 !== 5'b0 || bus.hready16 !== 1'b1 || bus.hresp16 !== 2'b00) begin failed++; $display("FAIL idle_trans got psel=%b hrdy=%b hresp=%b exp 0 1 00", bus.psel16, bus.hready16, bus.hresp16); end
  endtask

  task automatic test_back_to_back();
    set_slave(1, 1'b1, 1'b0, 32'h11111111);
    set_slave(4, 1'b1, 1'b0, 32'h44444444);
    addr_phase(32'h00A10008, 1'b0);
    tick(); bus_idle();
    tests++; if (bus.psel16 !== 5'b00010) begin failed++; $display("FAIL b2b_setup1 got=%b exp=00010", bus.psel16); end
    tick();
    tick();
    tests++; if (bus.hready16 !== 1'b1 || bus.hresp16 !== 2'b00 || bus.hrdata16 !== 32'h11111111) begin failed++; $display("FAIL b2b_done1 got hrdy=%b hresp=%b hrdata=%h exp 1 00 11111111", bus.hready16, bus.hresp16, bus.hrdata16); end
    addr_phase(32'h00A4FFFC, 1'b0);
    tick(); bus_idle();
    tests++; if (bus.psel16 !== 5'b10000 || bus.penable16 !== 1'b0 || bus.paddr16 !== 32'h00A4FFFC) begin failed++; $display("FAIL b2b_setup2 got psel=%b pen=%b paddr=%h exp 10000 0 00a4fffc", bus.psel16, bus.penable16, bus.paddr16); end
    tick();
    tests++; if (bus.psel16 !== 5'b10000 || bus.penable16 !== 1'b1) begin failed++; $display("FAIL b2b_access2 got psel=%b pen=%b exp 10000 1", bus.psel16, bus.penable16); end
    tick();
    tests++; if (bus.hready16 !== 1'b1 || bus.hresp16 !== 2'b00 || bus.hrdata16 !== 32'h44444444) begin failed++; $display("FAIL b2b_done2 got hrdy=%b hresp=%b hrdata=%h exp 1 00 44444444", bus.hready16, bus.hresp16, bus.hrdata16); end
    tick();
  endtask

  task automatic test_slverr();
    set_slave(3, 1'b1, 1'b1, 32'hCAFEF00D);
    addr_phase(32'h00A30000, 1'b0);
    tick(); bus_idle();
    tests++; if (bus.psel16 !== 5'b01000) begin failed++; $display("FAIL err_setup got=%b exp=01000", bus.psel16); end
    tick();
    tick();
    tests++; if (bus.hready16 !== 1'b0 || bus.hresp16 !== 2'b01 || bus.psel16 !== 5'b0 || bus.penable16 !== 1'b0) begin failed++; $display("FAIL err_err1 got hrdy=%b hresp=%b psel=%b pen=%b exp 0 01 0 0", bus.hready16, bus.hresp16, bus.psel16, bus.penable16); end
    tick();
    tests++; if (bus.hready16 !== 1'b1 || bus.hresp16 !== 2'b01) begin failed++; $display("FAIL err_err2 got hrdy=%b hresp=%b exp 1 01", bus.hready16, bus.hresp16); end
    tests++; if (bus.hrdata16 !== 32'h44444444) begin failed++; $display("FAIL err_hrdata_hold got=%h exp=44444444", bus.hrdata16); end
    tick();
    set_slave(3, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset_mid();
    set_slave(2, 1'b0, 1'b0, 32'hDEADBEEF);
    addr_phase(32'h00A20000, 1'b0);
    tick(); bus_idle();
    tick();
    tests++; if (bus.penable16 !== 1'b1) begin failed++; $display("FAIL rstmid_access got pen=%b exp 1", bus.penable16); end
    rstn = 1'b0;
    tick();
    tests++; if (bus.psel16 !== 5'b0 || bus.penable16 !== 1'b0 || bus.hready16 !== 1'b1 || bus.hresp16 !== 2'b00) begin failed++; $display("FAIL rstmid_abort got psel=%b pen=%b hrdy=%b hresp=%b exp 0 0 1 00", bus.psel16, bus.penable16, bus.hready16, bus.hresp16); end
    rstn = 1'b1;
    bus.pready16[2] = 1'b1;
    tick();
    tests++; if (bus.psel16 !== 5'b0 || bus.hrdata16 !== 32'h0 || bus.hresp16 !== 2'b00) begin failed++; $display("FAIL rstmid_nocomplete got psel=%b hrdata=%h hresp=%b exp 0 0 00", bus.psel16, bus.hrdata16, bus.hresp16); end
    tick();
  endtask

  task automatic test_timeout();
    set_slave(2, 1'b0, 1'b0, 32'h0);
    addr_phase(32'h00A20008, 1'b0);
    tick(); bus_idle();
    tick();
`ifdef APB_TIMEOUT_EN
    begin
      int n;
      n = 0;
      for (int k = 0; k < 40 && bus.penable16 === 1'b1; k++) begin
        n++;
        tick();
      end
      tests++; if (n !== 8) begin failed++; $display("FAIL tmo_cycles got=%0d exp=8", n); end
      tests++; if (bus.hready16 !== 1'b0 || bus.hresp16 !== 2'b01 || bus.psel16 !== 5'b0) begin failed++; $display("FAIL tmo_err1 got hrdy=%b hresp=%b psel=%b exp 0 01 0", bus.hready16, bus.hresp16, bus.psel16); end
      tick(); tick();
    end
`else
    repeat (20) tick();
    tests++; if (bus.penable16 !== 1'b1 || bus.hready16 !== 1'b0 || bus.psel16 !== 5'b00100) begin failed++; $display("FAIL notmo_wait got pen=%b hrdy=%b psel=%b exp 1 0 00100", bus.penable16, bus.hready16, bus.psel16); end
    bus.pready16[2] = 1'b1;
    tick();
    tests++; if (bus.hready16 !== 1'b1 || bus.hresp16 !== 2'b00) begin failed++; $display("FAIL notmo_done got hrdy=%b hresp=%b exp 1 00", bus.hready16, bus.hresp16); end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_wait();
    test_miss();
    test_back_to_back();
    test_slverr();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
